// File: rtl/rv32m_pkg.sv
// Shared RV32M definitions: op encodings, FSM states and datapath width.
package rv32m_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 5;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negation: turns a signed operand into its
// magnitude, or re-applies a sign to an unsigned iteration result.
module muldiv_signfix #(
  parameter int W = 32
) (
  input  logic [W-1:0] value_i,
  input  logic         negate_i,
  output logic [W-1:0] value_o
);

  assign value_o = negate_i ? -value_i : value_i;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. Fixed 34-cycle issue period:
// capture, 32 shift-add / restoring-subtract steps, sign fix, writeback pulse.
module muldiv_unit #(
  parameter int XLEN  = rv32m_pkg::XLEN,
  parameter int CNT_W = rv32m_pkg::CNT_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_addr,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      wb_addr,
  output logic            wb_en
);

  import rv32m_pkg::*;

  localparam int              PW      = 2 * XLEN;
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e           state_q;
  op_e              op_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  a_q, b_q, a_raw_q, quo_q, rem_q, result_q;
  logic [PW-1:0]    prod_q;
  logic             a_neg_q, b_neg_q, dz_q, ovf_q;
  logic             busy_q, done_q, wb_en_q;
  logic [4:0]       rd_q, wb_addr_q;

  // Operand conditioning from the raw register-file values.
  op_e             op_in;
  logic            a_signed, b_signed, a_neg, b_neg, in_dz, in_ovf;
  logic [XLEN-1:0] a_mag, b_mag;

  assign op_in    = op_e'(funct3);
  assign a_signed = (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
                    (op_in == OP_DIV)  || (op_in == OP_REM);
  assign b_signed = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
  assign a_neg    = a_signed & rs1_data[XLEN-1];
  assign b_neg    = b_signed & rs2_data[XLEN-1];
  assign in_dz    = (rs2_data == '0);
  assign in_ovf   = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                    (rs1_data == MIN_NEG) && (rs2_data == '1);

  muldiv_signfix #(.W(XLEN)) u_a_mag (.value_i(rs1_data), .negate_i(a_neg), .value_o(a_mag));
  muldiv_signfix #(.W(XLEN)) u_b_mag (.value_i(rs2_data), .negate_i(b_neg), .value_o(b_mag));

  // One multiply step and one divide step computed every CALC cycle.
  logic [XLEN:0]   add_sum, shifted, diff;
  logic [PW-1:0]   prod_d;
  logic [XLEN-1:0] quo_d, rem_d;

  // Shift-add multiply and restoring-divide next-state logic.
  always_comb begin
    // NOTE: every output of a combinational block gets a value before any
    // branch, so no path can leave it unassigned and infer a latch.
    add_sum = {1'b0, prod_q[PW-1:XLEN]} + (prod_q[0] ? {1'b0, a_q} : '0);
    prod_d  = {add_sum, prod_q[XLEN-1:1]};
    shifted = {rem_q, quo_q[XLEN-1]};
    diff    = shifted - {1'b0, b_q};
    rem_d   = diff[XLEN-1:0];
    quo_d   = {quo_q[XLEN-2:0], 1'b1};
    if (diff[XLEN]) begin
      rem_d = shifted[XLEN-1:0];
      quo_d = {quo_q[XLEN-2:0], 1'b0};
    end
  end

  // Sign correction of the unsigned iteration results.
  logic [PW-1:0]   prod_fix;
  logic [XLEN-1:0] quo_fix, rem_fix, result_d;

  muldiv_signfix #(.W(PW))   u_prod_fix (.value_i(prod_q), .negate_i(a_neg_q ^ b_neg_q), .value_o(prod_fix));
  muldiv_signfix #(.W(XLEN)) u_quo_fix  (.value_i(quo_q),  .negate_i(a_neg_q ^ b_neg_q), .value_o(quo_fix));
  muldiv_signfix #(.W(XLEN)) u_rem_fix  (.value_i(rem_q),  .negate_i(a_neg_q),           .value_o(rem_fix));

  // Result selection, with divide-by-zero and overflow overriding the iteration.
  always_comb begin
    result_d = prod_fix[XLEN-1:0];
    case (op_q)
      OP_MUL:                       result_d = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result_d = prod_fix[PW-1:XLEN];
      OP_DIV, OP_DIVU:              result_d = dz_q ? '1 : (ovf_q ? MIN_NEG : quo_fix);
      default:                      result_d = dz_q ? a_raw_q : (ovf_q ? '0 : rem_fix);
    endcase
  end

  // Control FSM with registered handshake outputs; DONE can accept the next op.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= OP_MUL;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      a_raw_q   <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      prod_q    <= '0;
      a_neg_q   <= 1'b0;
      b_neg_q   <= 1'b0;
      dz_q      <= 1'b0;
      ovf_q     <= 1'b0;
      rd_q      <= '0;
      result_q  <= '0;
      wb_addr_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wb_en_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q  <= 1'b0;
          wb_en_q <= 1'b0;
          if (start) begin
            op_q    <= op_in;
            rd_q    <= rd_addr;
            a_q     <= a_mag;
            b_q     <= b_mag;
            a_raw_q <= rs1_data;
            a_neg_q <= a_neg;
            b_neg_q <= b_neg;
            dz_q    <= in_dz;
            ovf_q   <= in_ovf;
            prod_q  <= {{XLEN{1'b0}}, b_mag};
            quo_q   <= a_mag;
            rem_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_CALC;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_CALC: begin
          prod_q <= prod_d;
          quo_q  <= quo_d;
          rem_q  <= rem_d;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST) state_q <= S_FIX;
        end
        default: begin
          result_q  <= result_d;
          wb_addr_q <= rd_q;
          done_q    <= 1'b1;
          wb_en_q   <= (rd_q != 5'd0);
          state_q   <= S_DONE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign result  = result_q;
  assign wb_addr = wb_addr_q;
  assign wb_en   = wb_en_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: op results, latency,
// held-start issue period, async reset abort and rd=0 writeback suppression.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic [4:0]  rd_addr = '0;
  logic        busy, done, wb_en;
  logic [31:0] result;
  logic [4:0]  wb_addr;

  int errors = 0;
  int checks = 0;

  muldiv_unit dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .funct3   (funct3),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .rd_addr  (rd_addr),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .wb_addr  (wb_addr),
    .wb_en    (wb_en)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one op, scramble the inputs after acceptance, then check latency,
  // result, writeback fields and the return to idle.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
    int n;
    bit seen, drop;
    @(negedge clk);
    start = 1'b1; funct3 = f3; rs1_data = a; rs2_data = b; rd_addr = rd;
    @(posedge clk); #1;
    start = 1'b0; funct3 = ~f3; rs1_data = ~a; rs2_data = ~b; rd_addr = ~rd;
    check({tag, "_busy_start"}, 32'(busy), 32'd1);
    n = 0; seen = 1'b0; drop = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (!busy) drop = 1'b1;
      if (done) seen = 1'b1;
    end
    check({tag, "_latency"}, 32'(n), 32'd34);
    check({tag, "_busy_held"}, 32'(drop), 32'd0);
    check({tag, "_result"}, result, exp);
    check({tag, "_wb_addr"}, 32'(wb_addr), 32'(rd));
    check({tag, "_wb_en"}, 32'(wb_en), 32'(rd != 5'd0));
    @(negedge clk);
    check({tag, "_done_clear"}, 32'(done), 32'd0);
    check({tag, "_busy_clear"}, 32'(busy), 32'd0);
    check({tag, "_result_hold"}, result, exp);
  endtask

  // Keep start high and change every input each cycle for 33 cycles.
  task automatic hold_garbage(output bit early, output bit drop);
    early = 1'b0; drop = 1'b0;
    for (int i = 1; i <= 33; i++) begin
      @(negedge clk);
      if (done) early = 1'b1;
      if (!busy) drop = 1'b1;
      funct3   = 3'(i);
      rs1_data = 32'(i) * 32'h0101_0101;
      rs2_data = 32'(i) + 32'd9;
      rd_addr  = 5'(i + 3);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit early, drop, saw_done;

    // Reset state.
    #12;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_wb_en", 32'(wb_en), 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_wb_addr", 32'(wb_addr), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Multiply family.
    run_op("mul",    3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB);
    run_op("mulh",   3'b001, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6,  32'h0000_0000);
    run_op("mulhu",  3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7,  32'h7FFF_FFFF);
    run_op("mulhsu", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8,  32'h8000_0000);

    // Divide family.
    run_op("div",    3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 5'd9,  32'hFFFF_FFFD);
    run_op("rem",    3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 5'd10, 32'hFFFF_FFFF);
    run_op("divu",   3'b101, 32'd100,       32'd7,         5'd11, 32'd14);
    run_op("remu",   3'b111, 32'd100,       32'd7,         5'd12, 32'd2);
    run_op("div_neg_divisor", 3'b100, 32'd20, 32'hFFFF_FFFA, 5'd13, 32'hFFFF_FFFD);
    run_op("rem_neg_divisor", 3'b110, 32'd20, 32'hFFFF_FFFA, 5'd14, 32'd2);

    // Divide by zero and signed overflow.
    run_op("divu_by_zero", 3'b101, 32'h0000_1234, 32'd0, 5'd15, 32'hFFFF_FFFF);
    run_op("rem_by_zero",  3'b110, 32'h0000_1234, 32'd0, 5'd16, 32'h0000_1234);
    run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h8000_0000);
    run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'h0000_0000);

    // Start held high: only the operands present at edges k and k+34 count.
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; rs1_data = 32'd3; rs2_data = 32'd5; rd_addr = 5'd1;
    @(posedge clk); #1;
    hold_garbage(early, drop);
    check("held1_no_early_done", 32'(early), 32'd0);
    check("held1_busy_held", 32'(drop), 32'd0);
    @(negedge clk);
    check("held1_done", 32'(done), 32'd1);
    check("held1_result", result, 32'd15);
    check("held1_wb_addr", 32'(wb_addr), 32'd1);
    funct3 = 3'b101; rs1_data = 32'd1000; rs2_data = 32'd10; rd_addr = 5'd2;
    @(posedge clk); #1;
    check("held2_busy_start", 32'(busy), 32'd1);
    check("held2_done_clear", 32'(done), 32'd0);
    hold_garbage(early, drop);
    check("held2_no_early_done", 32'(early), 32'd0);
    check("held2_busy_held", 32'(drop), 32'd0);
    @(negedge clk);
    start = 1'b0;
    check("held2_done", 32'(done), 32'd1);
    check("held2_result", result, 32'd100);
    check("held2_wb_addr", 32'(wb_addr), 32'd2);
    @(negedge clk);
    check("held2_busy_clear", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of CALC discards the operation.
    @(negedge clk);
    start = 1'b1; funct3 = 3'b101; rs1_data = 32'd77; rs2_data = 32'd3; rd_addr = 5'd4;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_wb_en", 32'(wb_en), 32'd0);
    check("rst_mid_result", result, 32'd0);
    #1 rst = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("rst_no_done", 32'(saw_done), 32'd0);

    // Normal op after reset, with rd=0 suppressing the write enable.
    run_op("mul_rd0", 3'b000, 32'd6, 32'd7, 5'd0, 32'd42);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
